// File: rtl/rr_arb_pkg.sv
// Shared types for the 2:1 round-robin arbitrated mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rr_arb_pkg;

    // Arbiter ownership state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    // Mux select encoding. last_owner reuses the same encoding.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/arb_hold_cnt.sv
// Counts consecutive owned cycles and flags when the owner has used its slot.
// Latency: expired is decoded from the registered count (same cycle as count).
// Backpressure: none; the parent decides whether to act on expired.
//
// Ports: clk, rst_n (async active-low), owned (arbiter not idle),
//        clr (ownership changes on the next edge), expired (count == MAX_HOLD-1).
module arb_hold_cnt #(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic owned,
    input  logic clr,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);

    logic [7:0] cnt;

    // Saturates at LIMIT so a lone owner with no competitor never wraps
    // back to zero and loses its expired status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !owned) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/rr_arb_mux_2_1.sv
// Two-requester round-robin arbiter driving a registered 2:1 data mux.
// Latency: grant, sel, y and y_vld all appear one cycle after the request is sampled.
// Backpressure: none; the owner holds its request for the whole transfer.
//
// Ports: clk, rst_n (async active-low); req_a/req_b requests, a/b data;
//        gnt_a/gnt_b ownership, sel (0 = a, 1 = b), y registered data, y_vld.
// Optional macro RR_ARB_TIMEOUT_EN: forces handover after MAX_HOLD owned
// cycles when the other side is waiting (instantiates arb_hold_cnt).
module rr_arb_mux_2_1
    import rr_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_vld
);

    state_t state;
    state_t state_nxt;
    logic   last_owner;   // SEL_A / SEL_B of the most recent owner
    logic   hold_expired;

`ifdef RR_ARB_TIMEOUT_EN
    arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .owned   (state != IDLE),
        .clr     (state_nxt != state),
        .expired (hold_expired)
    );
`else
    // MAX_HOLD has no effect without the timeout; its legal range never
    // includes 0, so this is a constant low.
    assign hold_expired = (MAX_HOLD == 0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    // Tie: serve whoever did not own the path last.
                    state_nxt = (last_owner == SEL_B) ? OWN_A : OWN_B;
                end else if (req_a) begin
                    state_nxt = OWN_A;
                end else if (req_b) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_A: begin
                // Direct handover avoids an idle bubble between owners.
                if (!req_a) begin
                    state_nxt = req_b ? OWN_B : IDLE;
                end else if (hold_expired && req_b) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    state_nxt = req_a ? OWN_A : IDLE;
                end else if (hold_expired && req_a) begin
                    state_nxt = OWN_A;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Mux output is registered for the next-state owner so y lines up
    // with the grant decoded from the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= SEL_B;
            sel        <= SEL_A;
            y          <= '0;
            y_vld      <= 1'b0;
        end else begin
            state <= state_nxt;
            y_vld <= (state_nxt != IDLE);
            case (state_nxt)
                OWN_A: begin
                    sel        <= SEL_A;
                    y          <= a;
                    last_owner <= SEL_A;
                end
                OWN_B: begin
                    sel        <= SEL_B;
                    y          <= b;
                    last_owner <= SEL_B;
                end
                default: begin
                    // IDLE: sel and y hold their last values.
                end
            endcase
        end
    end

    assign gnt_a = (state == OWN_A);
    assign gnt_b = (state == OWN_B);

endmodule
